// File: rtl/rom_bank_loader.sv
// Byte-stream frame loader: parses an address/length header, writes 16-bit words into
// one of two ROM banks and verifies an XOR checksum over the data bytes.
module rom_bank_loader #(
   parameter int BANK_DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        err_clear,
   output logic        wr_en,
   output logic        wr_bank,
   output logic [9:0]  wr_index,
   output logic [15:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [3:0] {
      S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI,
      S_DATA_LO, S_DATA_HI, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  addr_lo_q, addr_lo_d;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [7:0]  lo_q, lo_d;
   logic [15:0] words_left_q, words_left_d;
   logic [7:0]  csum_q, csum_d;
   logic        wr_en_q, wr_en_d;
   logic        wr_bank_q, wr_bank_d;
   logic [9:0]  wr_index_q, wr_index_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        done_q, done_d;
   logic [1:0]  err_code_q, err_code_d;

   logic        accept;
   logic        addr_hi_bad;
   logic [15:0] len_word;
   logic [16:0] end_idx;
   logic        len_overrun;

   assign accept      = in_valid && in_ready;
   // Only 0x0000-0x03FF (bank 0) and 0xC000-0xC3FF (bank 1) are loadable
   assign addr_hi_bad = (in_data[7:6] == 2'b01) || (in_data[7:6] == 2'b10) ||
                        (in_data[5:2] != 4'd0);
   assign len_word    = {in_data, len_lo_q};
   assign end_idx     = {7'd0, wr_index_q} + {1'b0, len_word};
   assign len_overrun = end_idx > 17'(BANK_DEPTH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_ADDR_LO;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ADDR_LO: if (accept) state_d = S_ADDR_HI;
         S_ADDR_HI: if (accept) state_d = addr_hi_bad ? S_ERR : S_LEN_LO;
         S_LEN_LO:  if (accept) state_d = S_LEN_HI;
         S_LEN_HI: begin
            if (accept) begin
               if (len_overrun)            state_d = S_ERR;
               else if (len_word == 16'd0) state_d = S_CSUM;
               else                        state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: if (accept) state_d = S_DATA_HI;
         S_DATA_HI: if (accept) state_d = (words_left_q == 16'd1) ? S_CSUM : S_DATA_LO;
         S_CSUM:    if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
         S_DONE:    state_d = S_ADDR_LO;
         S_ERR:     if (err_clear) state_d = S_ADDR_LO;
         default:   state_d = S_ADDR_LO;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      err      = 1'b0;
      case (state_q)
         S_ADDR_LO: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM: in_ready = 1'b1;
         S_ERR:   err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      addr_lo_d    = addr_lo_q;
      len_lo_d     = len_lo_q;
      lo_d         = lo_q;
      words_left_d = words_left_q;
      csum_d       = csum_q;
      wr_en_d      = 1'b0;
      wr_bank_d    = wr_bank_q;
      wr_index_d   = wr_index_q;
      wr_data_d    = wr_data_q;
      err_code_d   = err_code_q;

      // Advance after each write except the last, so a frame ending at 1023 leaves it there
      if (wr_en_q && (words_left_q != 16'd0)) wr_index_d = wr_index_q + 10'd1;

      case (state_q)
         S_ADDR_LO: if (accept) addr_lo_d = in_data;
         S_ADDR_HI: begin
            if (accept) begin
               if (addr_hi_bad) begin
                  err_code_d = 2'd1;
               end else begin
                  wr_bank_d  = in_data[7];
                  wr_index_d = {in_data[1:0], addr_lo_q};
               end
            end
         end
         S_LEN_LO: if (accept) len_lo_d = in_data;
         S_LEN_HI: begin
            if (accept) begin
               if (len_overrun) err_code_d   = 2'd2;
               else             words_left_d = len_word;
            end
         end
         S_DATA_LO: begin
            if (accept) begin
               lo_d   = in_data;
               csum_d = csum_q ^ in_data;
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               csum_d       = csum_q ^ in_data;
               wr_en_d      = 1'b1;
               wr_data_d    = {in_data, lo_q};
               words_left_d = words_left_q - 16'd1;
            end
         end
         S_CSUM:  if (accept && (in_data != csum_q)) err_code_d = 2'd3;
         S_ERR:   if (err_clear) err_code_d = 2'd0;
         default: ;
      endcase

      done_d = (state_d == S_DONE);
      if (state_d == S_ADDR_LO) csum_d = 8'd0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_lo_q    <= 8'd0;
         len_lo_q     <= 8'd0;
         lo_q         <= 8'd0;
         words_left_q <= 16'd0;
         csum_q       <= 8'd0;
         wr_en_q      <= 1'b0;
         wr_bank_q    <= 1'b0;
         wr_index_q   <= 10'd0;
         wr_data_q    <= 16'd0;
         done_q       <= 1'b0;
         err_code_q   <= 2'd0;
      end else begin
         addr_lo_q    <= addr_lo_d;
         len_lo_q     <= len_lo_d;
         lo_q         <= lo_d;
         words_left_q <= words_left_d;
         csum_q       <= csum_d;
         wr_en_q      <= wr_en_d;
         wr_bank_q    <= wr_bank_d;
         wr_index_q   <= wr_index_d;
         wr_data_q    <= wr_data_d;
         done_q       <= done_d;
         err_code_q   <= err_code_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_bank  = wr_bank_q;
   assign wr_index = wr_index_q;
   assign wr_data  = wr_data_q;
   assign done     = done_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_rom_bank_loader.sv
// Frame-level directed vectors for rom_bank_loader plus hand sequences for stalls,
// reset during a data write and the no-wrap end-of-bank case.
module tb_rom_bank_loader;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        err_clear;
   logic        wr_en;
   logic        wr_bank;
   logic [9:0]  wr_index;
   logic [15:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   rom_bank_loader #(.BANK_DEPTH(1024)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .err_clear (err_clear),
      .wr_en     (wr_en),
      .wr_bank   (wr_bank),
      .wr_index  (wr_index),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stream literal is right-aligned, first byte most significant
   typedef struct {
      logic [95:0] stream;
      int          nbytes;
      int          nwr;
      logic [26:0] wr0;
      logic [26:0] wr1;
      int          exp_done;
      logic [1:0]  exp_code;
   } vec_t;

   vec_t        vec [12];
   int          nvec;
   int          n_checks;
   int          n_errors;
   int          done_cnt;
   logic [26:0] wr_q [$];

   always @(negedge clk) begin
      if (wr_en) wr_q.push_back({wr_bank, wr_index, wr_data});
      if (done) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [26:0] w(input logic b, input int idx, input logic [15:0] d);
      logic [9:0] i10;
      i10 = idx[9:0];
      return {b, i10, d};
   endfunction

   task automatic add_vec(input logic [95:0] s, input int n, input int nw,
                          input logic [26:0] a, input logic [26:0] b,
                          input int dn, input logic [1:0] code);
      vec[nvec].stream   = s;
      vec[nvec].nbytes   = n;
      vec[nvec].nwr      = nw;
      vec[nvec].wr0      = a;
      vec[nvec].wr1      = b;
      vec[nvec].exp_done = dn;
      vec[nvec].exp_code = code;
      nvec++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int cnt;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1 for byte %0h", b);
      end
   endtask

   task automatic run_vec(input int vi);
      int          base_w;
      int          base_d;
      logic [26:0] exp_w;
      for (int k = 0; k < vec[vi].nbytes; k++) begin
         send_byte(vec[vi].stream[8*(vec[vi].nbytes-1-k) +: 8]);
         if (k == 0) begin
            base_w = wr_q.size();
            base_d = done_cnt;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d write_count", vi), wr_q.size() - base_w, vec[vi].nwr);
      for (int k = 0; k < vec[vi].nwr; k++) begin
         exp_w = (k == 0) ? vec[vi].wr0 : vec[vi].wr1;
         if (wr_q.size() > base_w + k)
            chk($sformatf("v%0d write%0d {bank,idx,data}", vi, k), wr_q[base_w+k], exp_w);
      end
      chk($sformatf("v%0d done_pulses", vi), done_cnt - base_d, vec[vi].exp_done);
      chk($sformatf("v%0d err", vi), err, vec[vi].exp_code != 2'd0);
      chk($sformatf("v%0d err_code", vi), err_code, vec[vi].exp_code);
      if (vec[vi].exp_code != 2'd0) begin
         chk($sformatf("v%0d in_ready_in_err", vi), in_ready, 1'b0);
         chk($sformatf("v%0d busy_in_err", vi), busy, 1'b1);
         err_clear = 1'b1;
         @(negedge clk);
         err_clear = 1'b0;
         chk($sformatf("v%0d err_after_clear", vi), err, 1'b0);
         chk($sformatf("v%0d err_code_after_clear", vi), err_code, 2'd0);
         chk($sformatf("v%0d in_ready_after_clear", vi), in_ready, 1'b1);
      end
      chk($sformatf("v%0d busy_idle", vi), busy, 1'b0);
      $display("vector %0d: %0d bytes, %0d writes, done=%0d, err_code=%0d", vi,
               vec[vi].nbytes, wr_q.size() - base_w, done_cnt - base_d, err_code);
   endtask

   initial begin
      logic [26:0] z;
      int          base_w;
      z         = '0;
      nvec      = 0;
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      err_clear = 1'b0;

      // Data checksum of 34 12 78 56 is 0x08
      add_vec(96'h00_00_02_00_34_12_78_56_08, 9, 2, w(0, 0, 16'h1234), w(0, 1, 16'h5678), 1, 2'd0);
      add_vec(96'hFE_C3_02_00_EF_BE_AD_DE_22, 9, 2, w(1, 1022, 16'hBEEF), w(1, 1023, 16'hDEAD), 1, 2'd0);
      add_vec(96'h00_40,                      2, 0, z, z, 0, 2'd1);
      add_vec(96'hFF_03_02_00,                4, 0, z, z, 0, 2'd2);
      add_vec(96'h10_00_02_00_34_12_78_56_09, 9, 2, w(0, 16, 16'h1234), w(0, 17, 16'h5678), 0, 2'd3);
      add_vec(96'h05_C0_00_00_00,             5, 0, z, z, 1, 2'd0);
      add_vec(96'h05_C0_00_00_01,             5, 0, z, z, 0, 2'd3);
      add_vec(96'h00_80,                      2, 0, z, z, 0, 2'd1);
      add_vec(96'h00_04,                      2, 0, z, z, 0, 2'd1);
      add_vec(96'h00_00_01_04,                4, 0, z, z, 0, 2'd2);
      add_vec(96'h00_C0_01_00_AA_55_FF,       7, 1, w(1, 0, 16'h55AA), z, 1, 2'd0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset wr_en", wr_en, 1'b0);
      chk("reset wr_index", wr_index, 10'd0);
      chk("reset wr_data", wr_data, 16'd0);
      chk("reset busy", busy, 1'b0);
      chk("reset err", err, 1'b0);
      chk("reset err_code", err_code, 2'd0);
      chk("reset done", done, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("in_ready after release", in_ready, 1'b1);

      for (int i = 0; i < nvec; i++) run_vec(i);

      // Last word lands on index 1023 and the index must not wrap afterwards
      run_vec(1);
      chk("no wrap wr_index", wr_index, 10'd1023);
      $display("seq nowrap: wr_index=%0d", wr_index);

      // Stall between DATA_LO and DATA_HI: no write, index held
      send_byte(8'h07);
      base_w = wr_q.size();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d wr_en", k), wr_en, 1'b0);
         chk($sformatf("stall%0d wr_index", k), wr_index, 10'd7);
      end
      chk("stall busy", busy, 1'b1);
      send_byte(8'h22);
      send_byte(8'h33);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("stall write_count", wr_q.size() - base_w, 1);
      if (wr_q.size() > base_w) chk("stall write", wr_q[base_w], w(0, 7, 16'h2211));
      chk("stall err", err, 1'b0);
      $display("seq stall: writes=%0d", wr_q.size() - base_w);

      // Reset on the cycle DATA_HI is accepted suppresses the pending write
      send_byte(8'h05);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hAB);
      @(negedge clk);
      base_w   = wr_q.size();
      in_data  = 8'hCD;
      in_valid = 1'b1;
      rst_n    = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk("midrst wr_en", wr_en, 1'b0);
      chk("midrst wr_index", wr_index, 10'd0);
      chk("midrst wr_data", wr_data, 16'd0);
      chk("midrst wr_bank", wr_bank, 1'b0);
      chk("midrst busy", busy, 1'b0);
      chk("midrst done", done, 1'b0);
      chk("midrst err_code", err_code, 2'd0);
      rst_n = 1'b1;
      #1;
      chk("midrst in_ready", in_ready, 1'b1);
      repeat (2) @(negedge clk);
      chk("midrst write_count", wr_q.size() - base_w, 0);
      $display("seq midreset: writes=%0d", wr_q.size() - base_w);
      run_vec(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
